// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types, default widths and ALU op codes for alu_arb_seq
package alu_arb_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CTRL_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_NOT = 2;
    localparam int unsigned OP_SHL = 3;
    localparam int unsigned OP_SHR = 4;
    localparam int unsigned OP_AND = 5;
    localparam int unsigned OP_OR  = 6;
    localparam int unsigned OP_SLT = 7;

endpackage

// File: rtl/alu_arb_pick.sv
// rtl/alu_arb_pick.sv - two-requester grant logic; ALU_ARB_RR_EN selects round-robin over fixed priority
module alu_arb_pick (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid_i,
    input  logic       take_i,
    output logic [1:0] grant_o
);

`ifdef ALU_ARB_RR_EN
    // last_q names the requester granted most recently; resets to 1 so requester 0 wins the first tie
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (take_i) begin
            last_q <= grant_o[1];
        end
    end

    always_comb begin
        grant_o = req_valid_i;
        if (req_valid_i == 2'b11) begin
            grant_o = last_q ? 2'b01 : 2'b10;
        end
    end
`else
    logic unused_pick;
    assign unused_pick = clk ^ rst ^ take_i;

    always_comb begin
        grant_o = 2'b00;
        if (req_valid_i[0]) begin
            grant_o = 2'b01;
        end else if (req_valid_i[1]) begin
            grant_o = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/alu_arb_seq.sv
// rtl/alu_arb_seq.sv - arbitrates two requesters onto one shared ALU with a 3-state sequencer; ALU_ARB_RR_EN enables round-robin ties
module alu_arb_seq
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    input  logic [2*CTRL_W-1:0] req_ctrl,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [CTRL_W-1:0]   alu_control,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_zero,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_zero,
    output logic                busy
);

    state_t              state_q;
    logic [DATA_W-1:0]   op_a_q;
    logic [DATA_W-1:0]   op_b_q;
    logic [CTRL_W-1:0]   op_ctrl_q;
    logic                id_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_zero_q;
    logic [1:0]          grant;
    logic                take;
    logic                sel;

    alu_arb_pick u_pick (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid),
        .take_i      (take),
        .grant_o     (grant)
    );

    // rst gates ready so nothing looks acceptable while reset is held
    assign req_ready = (state_q == ST_IDLE && !rst) ? grant : 2'b00;
    assign take      = |req_ready;
    assign sel       = req_ready[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_ctrl_q  <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        op_a_q    <= sel ? req_a[DATA_W +: DATA_W]    : req_a[0 +: DATA_W];
                        op_b_q    <= sel ? req_b[DATA_W +: DATA_W]    : req_b[0 +: DATA_W];
                        op_ctrl_q <= sel ? req_ctrl[CTRL_W +: CTRL_W] : req_ctrl[0 +: CTRL_W];
                        id_q      <= sel;
                        state_q   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_data_q <= alu_result;
                    rsp_zero_q <= alu_zero;
                    state_q    <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_a       = op_a_q;
    assign alu_b       = op_b_q;
    assign alu_control = op_ctrl_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_id      = id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_zero    = rsp_zero_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arb_seq.sv
// tb/tb_alu_arb_seq.sv - directed-vector bench for alu_arb_seq with a behavioural shared ALU
module tb_alu_arb_seq;
    import alu_arb_pkg::*;

    localparam int DW = 16;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_a = '0;
    logic [2*DW-1:0] req_b = '0;
    logic [2*CW-1:0] req_ctrl = '0;
    logic [DW-1:0]   alu_a, alu_b, alu_result;
    logic [CW-1:0]   alu_control;
    logic            alu_zero;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic            rsp_id;
    logic [DW-1:0]   rsp_data;
    logic            rsp_zero;
    logic            busy;

    int vectors = 0;
    int miscompares = 0;

    alu_arb_seq #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ctrl    (req_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_control (alu_control),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .rsp_zero    (rsp_zero),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_result = '0;
        case (alu_control)
            CW'(OP_ADD): alu_result = alu_a + alu_b;
            CW'(OP_SUB): alu_result = alu_a - alu_b;
            CW'(OP_NOT): alu_result = ~alu_a;
            CW'(OP_SHL): alu_result = alu_a << 1;
            CW'(OP_SHR): alu_result = alu_a >> 1;
            CW'(OP_AND): alu_result = alu_a & alu_b;
            CW'(OP_OR):  alu_result = alu_a | alu_b;
            CW'(OP_SLT): alu_result = DW'($signed(alu_a) < $signed(alu_b));
            default:     alu_result = '0;
        endcase
    end
    assign alu_zero = (alu_result == '0);

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rsp(input string tag);
        int i = 0;
        while (!rsp_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        expect_eq(tag, {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int  n;
    logic exp_id [4];

    initial begin
        // reset held 3 cycles with both requesters asking
        req_valid = 2'b11;
        repeat (3) begin
            @(negedge clk);
            expect_eq("rst_ready", {30'd0, req_ready}, 32'd0);
            expect_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            expect_eq("rst_busy", {31'd0, busy}, 32'd0);
        end
        expect_eq("rst_alu_a", {16'd0, alu_a}, 32'd0);
        expect_eq("rst_alu_b", {16'd0, alu_b}, 32'd0);
        expect_eq("rst_alu_ctrl", {28'd0, alu_control}, 32'd0);
        rst = 1'b0;

        // single requester 0: 5 + 3
        req_valid = 2'b01;
        req_a = {16'd7, 16'd5};
        req_b = {16'd7, 16'd3};
        req_ctrl = {4'd1, 4'd0};
        #1;
        expect_eq("single_ready", {30'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        expect_eq("exec_busy", {31'd0, busy}, 32'd1);
        expect_eq("exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        expect_eq("exec_alu_a", {16'd0, alu_a}, 32'd5);
        expect_eq("exec_alu_b", {16'd0, alu_b}, 32'd3);
        expect_eq("exec_ready", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        expect_eq("resp_valid", {31'd0, rsp_valid}, 32'd1);
        expect_eq("resp_id", {31'd0, rsp_id}, 32'd0);
        expect_eq("resp_data", {16'd0, rsp_data}, 32'd8);
        expect_eq("resp_zero", {31'd0, rsp_zero}, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        expect_eq("done_busy", {31'd0, busy}, 32'd0);
        expect_eq("done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;

        // both requesters continuously valid from a fresh reset
        pulse_reset();
`ifdef ALU_ARB_RR_EN
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_id = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                expect_eq($sformatf("tie_id%0d", n), {31'd0, rsp_id}, {31'd0, exp_id[n]});
                expect_eq($sformatf("tie_data%0d", n), {16'd0, rsp_data}, exp_id[n] ? 32'd0 : 32'd8);
                expect_eq($sformatf("tie_zero%0d", n), {31'd0, rsp_zero}, exp_id[n] ? 32'd1 : 32'd0);
                n++;
            end
        end
        expect_eq("tie_count", n, 32'd4);
        req_valid = 2'b00;
        @(negedge clk);
        rsp_ready = 1'b0;
        @(negedge clk);

        // backpressure on requester 1: 9 - 4
        req_a = {16'd9, 16'd5};
        req_b = {16'd4, 16'd3};
        req_valid = 2'b10;
        wait_rsp("bp_wait");
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            expect_eq("bp_data", {16'd0, rsp_data}, 32'd5);
            expect_eq("bp_id", {31'd0, rsp_id}, 32'd1);
            expect_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
            expect_eq("bp_ready", {30'd0, req_ready}, 32'd0);
            expect_eq("bp_busy", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        expect_eq("bp_release_busy", {31'd0, busy}, 32'd0);
        expect_eq("bp_release_valid", {31'd0, rsp_valid}, 32'd0);

        // reset during EXEC drops the operation
        req_valid = 2'b01;
        @(negedge clk);
        expect_eq("mid_exec_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        req_valid = 2'b00;
        #1;
        expect_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        expect_eq("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            expect_eq("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // requester 1: 12 & 10
        req_a = {16'd12, 16'd5};
        req_b = {16'd10, 16'd3};
        req_ctrl = {4'd5, 4'd0};
        req_valid = 2'b10;
        wait_rsp("and_wait");
        req_valid = 2'b00;
        expect_eq("and_id", {31'd0, rsp_id}, 32'd1);
        expect_eq("and_data", {16'd0, rsp_data}, 32'd8);
        expect_eq("and_zero", {31'd0, rsp_zero}, 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        expect_eq("and_done_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
